detection_reporter: RTL and testbench

Downstream stage of the HOG/SVM image processor. It consumes the per-slide-window classification results (`o_valid`, `is_person`, `sw_id`) and buffers every positive window as a 32-bit detection record. At the end of each frame it appends a summary record, and it drains all records to the host interconnect over an AXI-Stream master with backpressure. The SVM output has no ready signal, so this block never stalls its input: it drops hits when the buffer is full and flags the loss.

---
 rtl/detection_pkg.sv | 47 ++++
 rtl/det_fifo.sv | 71 +++++++
 rtl/detection_reporter.sv | 133 +++++++++++++
 tb/tb_detection_reporter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/detection_pkg.sv
// detection_pkg
// Shared definitions for the detection reporter: record type codes, field
// positions/widths of the 32-bit detection record, the packed record type
// and a helper that assembles a record from its fields.
package detection_pkg;

  typedef enum logic [1:0] {
    REC_NONE = 2'b00,
    REC_HIT  = 2'b01,
    REC_SUM  = 2'b10
  } rec_type_e;

  localparam int REC_W        = 32;
  localparam int REC_TYPE_LSB = 30;
  localparam int REC_TYPE_W   = 2;
  localparam int REC_ID_W     = 11;
  localparam int REC_FRAME_W  = 16;

  // Hit counter saturates at the largest value the id/count field can hold.
  localparam logic [REC_ID_W-1:0] HIT_CNT_MAX = '1;

  // [31:30] type, [29:28] reserved, [27] frame loss,
  // [26:16] window id (hit) or hit count (summary), [15:0] frame counter.
  typedef struct packed {
    rec_type_e               rec_type;
    logic [1:0]              rsvd;
    logic                    loss;
    logic [REC_ID_W-1:0]     id_cnt;
    logic [REC_FRAME_W-1:0]  frame;
  } det_record_t;

  function automatic det_record_t make_record(
    input rec_type_e               rec_type,
    input logic                    loss,
    input logic [REC_ID_W-1:0]     id_cnt,
    input logic [REC_FRAME_W-1:0]  frame
  );
    det_record_t rec;
    rec.rec_type = rec_type;
    rec.rsvd     = 2'b00;
    rec.loss     = loss;
    rec.id_cnt   = id_cnt;
    rec.frame    = frame;
    return rec;
  endfunction

endpackage

// File: rtl/det_fifo.sv
// det_fifo
// Synchronous show-ahead FIFO with two write ports. Port A is written first
// and port B lands in the following slot, so two records can enter in one
// cycle while keeping their order. The head entry is visible on head_o
// whenever the FIFO is not empty (reads zero when empty).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push_a_i / data_a_i   first write port
//   push_b_i / data_b_i   second write port (ordered after port A)
//   pop_i                 remove head entry (ignored when empty)
//   head_o, empty_o       show-ahead head and empty flag
//   count_o               current occupancy
// The caller guarantees it never writes more entries than are free.
module det_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_a_i,
  input  logic [WIDTH-1:0]           data_a_i,
  input  logic                       push_b_i,
  input  logic [WIDTH-1:0]           data_b_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_b_ptr;
  logic             pop_ok;

  // Port B follows port A when both write in the same cycle.
  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    wr_b_ptr = wr_ptr_q + PTR_W'(push_a_i);
    mem_d    = mem_q;
    if (push_a_i) mem_d[wr_ptr_q] = data_a_i;
    if (push_b_i) mem_d[wr_b_ptr] = data_b_i;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset, so the head is masked while empty.
  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/detection_reporter.sv
// detection_reporter
// Buffers every positive slide-window classification as a hit record, adds a
// summary record when the last window of a frame arrives, and streams all
// records out over an AXI-Stream master. The input cannot be stalled, so
// records that do not fit are dropped and flagged.
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   det_valid_i, det_person_i, det_sw_id_i    classification result
//   m_tdata_o, m_tvalid_o, m_tlast_o, m_tready_i   AXI-Stream master
//   frame_done_o                              one-cycle pulse per completed frame
//   overflow_o                                sticky record-drop flag
module detection_reporter
  import detection_pkg::*;
#(
  parameter int SW_W         = 11,
  parameter int SW_NUM       = 495,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_CNT_W  = 16,
  parameter int AXIS_TDATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    det_valid_i,
  input  logic                    det_person_i,
  input  logic [SW_W-1:0]         det_sw_id_i,
  output logic [AXIS_TDATA_W-1:0] m_tdata_o,
  output logic                    m_tvalid_o,
  output logic                    m_tlast_o,
  input  logic                    m_tready_i,
  output logic                    frame_done_o,
  output logic                    overflow_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SW_W-1:0]  LAST_ID    = SW_W'(SW_NUM - 1);
  localparam logic [CNT_W-1:0] HIT_LIMIT  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FIFO_LIMIT = CNT_W'(FIFO_DEPTH);

  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [REC_ID_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic                    frame_loss_q, frame_loss_d;
  logic                    overflow_q, overflow_d;
  logic                    frame_done_q, frame_done_d;

  logic                    id_ok, is_hit, is_last;
  logic                    push_hit, push_sum;
  logic [CNT_W-1:0]        occ_after;
  logic [REC_FRAME_W-1:0]  frame_field;
  det_record_t             hit_rec, sum_rec;

  logic [AXIS_TDATA_W-1:0] fifo_head;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_pop;

  // Hit handling comes first; the summary sees this cycle's hit already
  // counted and, if dropped, already reflected in the loss flag. Occupancy
  // checks ignore a same-cycle pop. The hit threshold keeps one slot free
  // so the summary survives unless downstream stalls for a whole frame.
  always_comb begin
    id_ok     = det_valid_i && (det_sw_id_i <= LAST_ID);
    is_hit    = id_ok && det_person_i;
    is_last   = id_ok && (det_sw_id_i == LAST_ID);
    push_hit  = is_hit && (fifo_count < HIT_LIMIT);
    occ_after = fifo_count + CNT_W'(push_hit);
    push_sum  = is_last && (occ_after < FIFO_LIMIT);

    frame_cnt_d  = frame_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    frame_loss_d = frame_loss_q;
    overflow_d   = overflow_q;
    frame_done_d = is_last;

    if (is_hit && (hit_cnt_q != HIT_CNT_MAX)) hit_cnt_d = hit_cnt_q + REC_ID_W'(1);
    if (is_hit && !push_hit) begin
      frame_loss_d = 1'b1;
      overflow_d   = 1'b1;
    end
    if (is_last && !push_sum) overflow_d = 1'b1;

    frame_field = REC_FRAME_W'(frame_cnt_q);
    hit_rec = make_record(REC_HIT, 1'b0, REC_ID_W'(det_sw_id_i), frame_field);
    sum_rec = make_record(REC_SUM, frame_loss_d, hit_cnt_d, frame_field);

    if (is_last) begin
      frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
      hit_cnt_d    = '0;
      frame_loss_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q  <= '0;
      hit_cnt_q    <= '0;
      frame_loss_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_loss_q <= frame_loss_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // A last-window hit and its summary enter together: hit on port A,
  // summary on port B right behind it.
  det_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXIS_TDATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a_i (push_hit),
    .data_a_i (AXIS_TDATA_W'(hit_rec)),
    .push_b_i (push_sum),
    .data_b_i (AXIS_TDATA_W'(sum_rec)),
    .pop_i    (fifo_pop),
    .head_o   (fifo_head),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign fifo_pop     = m_tvalid_o && m_tready_i;
  assign m_tvalid_o   = !fifo_empty;
  assign m_tdata_o    = fifo_head;
  assign m_tlast_o    = (m_tdata_o[REC_TYPE_LSB +: REC_TYPE_W] == REC_SUM);
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_detection_reporter.sv
// tb_detection_reporter
// Directed bench for detection_reporter: hit/summary records, last-window
// hit, overflow, random backpressure, invalid id, frame counter wrap and
// mid-frame reset. Popped records are collected by a monitor and compared
// against hand-computed values.
module tb_detection_reporter;

  localparam int SW_W = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            det_valid_i;
  logic            det_person_i;
  logic [SW_W-1:0] det_sw_id_i;
  logic [31:0]     m_tdata_o;
  logic            m_tvalid_o;
  logic            m_tlast_o;
  logic            m_tready_i;
  logic            frame_done_o;
  logic            overflow_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rec_q[$];
  logic        last_q[$];
  int          done_cnt = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  detection_reporter #(
    .SW_W         (SW_W),
    .SW_NUM       (495),
    .FIFO_DEPTH   (16),
    .FRAME_CNT_W  (16),
    .AXIS_TDATA_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .det_valid_i  (det_valid_i),
    .det_person_i (det_person_i),
    .det_sw_id_i  (det_sw_id_i),
    .m_tdata_o    (m_tdata_o),
    .m_tvalid_o   (m_tvalid_o),
    .m_tlast_o    (m_tlast_o),
    .m_tready_i   (m_tready_i),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Collects handshaked records and checks that a stalled record holds.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        checkOutput("hold_valid", {31'b0, m_tvalid_o}, 32'd1);
        checkOutput("hold_data", m_tdata_o, prev_data);
      end
      if (m_tvalid_o && m_tready_i) begin
        rec_q.push_back(m_tdata_o);
        last_q.push_back(m_tlast_o);
      end
      if (frame_done_o) done_cnt++;
    end
    prev_hold = !rst && m_tvalid_o && !m_tready_i;
    prev_data = m_tdata_o;
  end

  task automatic applyStimulus(input logic [SW_W-1:0] id, input logic person);
    det_valid_i  = 1'b1;
    det_sw_id_i  = id;
    det_person_i = person;
    @(posedge clk); #1;
    det_valid_i  = 1'b0;
    det_person_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    m_tready_i = 1'b1;
    while (m_tvalid_o && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("drain_empty", {31'b0, m_tvalid_o}, 32'd0);
  endtask

  task automatic clearRecords();
    rec_q.delete();
    last_q.delete();
  endtask

  initial begin
    rst          = 1'b1;
    det_valid_i  = 1'b0;
    det_person_i = 1'b0;
    det_sw_id_i  = '0;
    m_tready_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", {31'b0, m_tvalid_o}, 32'd0);
    checkOutput("rst_tdata", m_tdata_o, 32'd0);
    checkOutput("rst_tlast", {31'b0, m_tlast_o}, 32'd0);
    checkOutput("rst_frame_done", {31'b0, frame_done_o}, 32'd0);
    checkOutput("rst_overflow", {31'b0, overflow_o}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Frame 0: three hits then a non-person last window.
    m_tready_i = 1'b1;
    applyStimulus(11'd5, 1'b1);
    checkOutput("A_latency_valid", {31'b0, m_tvalid_o}, 32'd1);
    checkOutput("A_latency_data", m_tdata_o, 32'h4005_0000);
    applyStimulus(11'd40, 1'b1);
    applyStimulus(11'd300, 1'b1);
    applyStimulus(11'd494, 1'b0);
    checkOutput("A_frame_done_hi", {31'b0, frame_done_o}, 32'd1);
    idle(1);
    checkOutput("A_frame_done_lo", {31'b0, frame_done_o}, 32'd0);
    drain(20);
    checkOutput("A_count", rec_q.size(), 32'd4);
    checkOutput("A_rec0", rec_q[0], 32'h4005_0000);
    checkOutput("A_rec1", rec_q[1], 32'h4028_0000);
    checkOutput("A_rec2", rec_q[2], 32'h412C_0000);
    checkOutput("A_rec3", rec_q[3], 32'h8003_0000);
    checkOutput("A_last0", {31'b0, last_q[0]}, 32'd0);
    checkOutput("A_last3", {31'b0, last_q[3]}, 32'd1);
    checkOutput("A_done_cnt", done_cnt, 32'd1);
    clearRecords();

    // Frame 1: last window is itself a hit.
    applyStimulus(11'd494, 1'b1);
    checkOutput("B_head_hit", m_tdata_o, 32'h41EE_0001);
    checkOutput("B_head_tlast", {31'b0, m_tlast_o}, 32'd0);
    idle(1);
    checkOutput("B_head_sum", m_tdata_o, 32'h8001_0001);
    checkOutput("B_sum_tlast", {31'b0, m_tlast_o}, 32'd1);
    drain(20);
    checkOutput("B_count", rec_q.size(), 32'd2);
    checkOutput("B_rec0", rec_q[0], 32'h41EE_0001);
    checkOutput("B_rec1", rec_q[1], 32'h8001_0001);
    checkOutput("B_done_cnt", done_cnt, 32'd2);
    clearRecords();

    // Frame 2: out-of-range id is ignored entirely.
    applyStimulus(11'd600, 1'b1);
    idle(3);
    checkOutput("C_no_valid", {31'b0, m_tvalid_o}, 32'd0);
    checkOutput("C_no_rec", rec_q.size(), 32'd0);
    applyStimulus(11'd494, 1'b0);
    checkOutput("C_sum", m_tdata_o, 32'h8000_0002);
    drain(20);
    checkOutput("C_count", rec_q.size(), 32'd1);
    clearRecords();

    // Frame 3: overflow with the output stalled.
    m_tready_i = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(SW_W'(i), 1'b1);
    applyStimulus(11'd494, 1'b0);
    checkOutput("D_overflow", {31'b0, overflow_o}, 32'd1);
    checkOutput("D_head", m_tdata_o, 32'h4000_0003);
    idle(5);
    checkOutput("D_head_held", m_tdata_o, 32'h4000_0003);
    checkOutput("D_no_pop", rec_q.size(), 32'd0);
    drain(60);
    checkOutput("D_count", rec_q.size(), 32'd16);
    for (int i = 0; i < 15; i++)
      checkOutput($sformatf("D_rec%0d", i), rec_q[i], {2'b01, 3'b000, 11'(i), 16'h0003});
    checkOutput("D_sum", rec_q[15], 32'h8814_0003);
    checkOutput("D_sum_tlast", {31'b0, last_q[15]}, 32'd1);
    clearRecords();

    // Frame 4: random backpressure; stability is checked by the monitor.
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(SW_W'(10 + i), 1'b1);
        applyStimulus(11'd494, 1'b1);
      end
      begin
        repeat (40) begin
          m_tready_i = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    drain(40);
    checkOutput("E_count", rec_q.size(), 32'd10);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("E_rec%0d", i), rec_q[i], {2'b01, 3'b000, 11'(10 + i), 16'h0004});
    checkOutput("E_last_hit", rec_q[8], 32'h41EE_0004);
    checkOutput("E_sum", rec_q[9], 32'h8009_0004);
    clearRecords();

    // Frames 5..65534 are empty, bringing the frame counter to 0xFFFF.
    m_tready_i = 1'b1;
    for (int f = 5; f < 65535; f++) applyStimulus(11'd494, 1'b0);
    drain(10);
    checkOutput("F_pre_wrap", rec_q[$], 32'h8000_FFFE);
    clearRecords();
    applyStimulus(11'd7, 1'b1);
    applyStimulus(11'd494, 1'b0);
    applyStimulus(11'd3, 1'b1);
    drain(20);
    checkOutput("F_count", rec_q.size(), 32'd3);
    checkOutput("F_hit_ffff", rec_q[0], 32'h4007_FFFF);
    checkOutput("F_sum_ffff", rec_q[1], 32'h8001_FFFF);
    checkOutput("F_hit_wrap", rec_q[2], 32'h4003_0000);
    clearRecords();

    // Reset with records pending, then a clean frame.
    m_tready_i = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(SW_W'(i), 1'b1);
    checkOutput("G_pending", {31'b0, m_tvalid_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("G_rst_tvalid", {31'b0, m_tvalid_o}, 32'd0);
    checkOutput("G_rst_tdata", m_tdata_o, 32'd0);
    checkOutput("G_rst_overflow", {31'b0, overflow_o}, 32'd0);
    checkOutput("G_rst_tlast", {31'b0, m_tlast_o}, 32'd0);
    clearRecords();
    m_tready_i = 1'b1;
    applyStimulus(11'd20, 1'b1);
    applyStimulus(11'd21, 1'b1);
    applyStimulus(11'd494, 1'b0);
    drain(20);
    checkOutput("G_count", rec_q.size(), 32'd3);
    checkOutput("G_rec0", rec_q[0], 32'h4014_0000);
    checkOutput("G_rec1", rec_q[1], 32'h4015_0000);
    checkOutput("G_sum", rec_q[2], 32'h8002_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
